// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-write controller:
// FSM states, frame geometry and the PWM peripheral register map.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam int FRAME_W   = 16;
  localparam int RW_BIT    = FRAME_W - 1;
  localparam int BIT_CNT_W = $clog2(FRAME_W);

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

endpackage

// File: rtl/spi_reg_writer_if.sv
// Request/response bundle between a requester (master) and the SPI
// register writer (slave).
interface spi_reg_writer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_rw;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_data, req_rw,
    input  req_ready, busy, done, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_rw,
    output req_ready, busy, done, rsp_data
  );
endinterface

// File: rtl/spi_sclk_div.sv
// SCLK half-period divider: phase_tick marks the last clk cycle of each
// half-period while enabled; the counter reloads rather than wrapping.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_tick
);
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || cnt == 8'd0) cnt <= RELOAD;
    else                           cnt <= cnt - 8'd1;
  end

  assign phase_tick = en && (cnt == 8'd0);
endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0, MSB-first controller issuing 16-bit register frames.
// Optional read support is built when SPI_READ_EN is defined.
module spi_reg_writer
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  spi_reg_writer_if.slave bus,
  output logic            sclk,
  output logic            copi,
  input  logic            cipo,
  output logic            ncs
);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

  state_t               state;
  logic [FRAME_W-1:0]   shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 ready, busy_r, done_r;
  logic                 tick, accept, rw_bit;
  logic [FRAME_W-1:0]   frame_in;

  assign accept   = bus.req_valid && ready;
  assign frame_in = {rw_bit, bus.req_addr, bus.req_data};

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .rst        (rst),
    .en         (busy_r),
    .phase_tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ncs     <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      ready   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            ncs     <= 1'b0;
            copi    <= frame_in[RW_BIT];
            shreg   <= frame_in;
            bit_cnt <= LAST_BIT;
            ready   <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // falling edge: advance to the next bit, or park on bit0
              sclk <= 1'b0;
              if (bit_cnt == '0) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                copi    <= shreg[FRAME_W-2];
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state  <= GAP;
            ncs    <= 1'b1;
            done_r <= 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

`ifdef SPI_READ_EN
  localparam logic [BIT_CNT_W-1:0] DATA_TOP = BIT_CNT_W'(DATA_W - 1);

  logic              rd_frame;
  logic [DATA_W-1:0] rx, rsp;

  assign rw_bit = bus.req_rw;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_frame <= 1'b0;
      rx       <= '0;
      rsp      <= '0;
    end else begin
      if (state == IDLE && accept) begin
        rd_frame <= !bus.req_rw;
        rx       <= '0;
      end
      // sample on the rising sclk edge of each data bit
      if (state == SHIFT && tick && !sclk && rd_frame && bit_cnt <= DATA_TOP)
        rx <= {rx[DATA_W-2:0], cipo};
      if (state == HOLD && tick && rd_frame)
        rsp <= rx;
    end
  end

  assign bus.rsp_data = rsp;
`else
  logic unused_rd;
  assign unused_rd    = &{1'b0, bus.req_rw, cipo};
  assign rw_bit       = 1'b1;
  assign bus.rsp_data = '0;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed self-checking bench for spi_reg_writer (CLK_DIV=4 and CLK_DIV=1).
module tb_spi_reg_writer;
  import spi_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_writer_if #(.ADDR_W(7), .DATA_W(8)) if0 ();
  spi_reg_writer_if #(.ADDR_W(7), .DATA_W(8)) if1 ();

  logic sclk0, copi0, ncs0, cipo0;
  logic sclk1, copi1, ncs1;
  logic cipo1 = 1'b0;

  spi_reg_writer #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .sclk(sclk0), .copi(copi0), .cipo(cipo0), .ncs(ncs0)
  );
  spi_reg_writer #(.CLK_DIV(1), .ADDR_W(7), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .sclk(sclk1), .copi(copi1), .cipo(cipo1), .ncs(ncs1)
  );

  // bus monitors: capture copi on each sclk rise
  logic [15:0] cap0 = '0, cap1 = '0;
  int rises0 = 0, rises1 = 0;
  always @(posedge sclk0) begin cap0 <= {cap0[14:0], copi0}; rises0 <= rises0 + 1; end
  always @(posedge sclk1) begin cap1 <= {cap1[14:0], copi1}; rises1 <= rises1 + 1; end

  // peripheral model: returns rd_byte MSB first during data bits
  logic [7:0] rd_byte = 8'h3C;
  int rbase = 0;
  always_comb begin
    cipo0 = 1'b0;
    if (rises0 - rbase >= 8 && rises0 - rbase < 16) cipo0 = rd_byte[15 - (rises0 - rbase)];
  end

  int checks = 0, errors = 0;

  task automatic run_frame(input logic [6:0] a, input logic [7:0] d, input logic rw,
                           output int ncs_low, output int done_n, output int done_at,
                           output int rise_n, output int acc_ok);
    int acc, r0;
    acc_ok = 0; ncs_low = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_addr = a; if0.req_data = d; if0.req_rw = rw;
    for (int k = 0; k < 200; k++) begin
      if (if0.req_ready) begin acc_ok = 1; break; end
      @(negedge clk);
    end
    acc = cyc + 1; r0 = rises0; rbase = rises0;
    @(negedge clk);
    if0.req_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!ncs0) ncs_low++;
      if (if0.done) begin done_n++; done_at = cyc - acc; end
      if (if0.req_ready) break;
      @(negedge clk);
    end
    rise_n = rises0 - r0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ncs0 !== 1'b1) begin errors++; $display("FAIL reset_ncs got %0b exp 1", ncs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %0b exp 0", sclk0); end
    checks++; if (copi0 !== 1'b0) begin errors++; $display("FAIL reset_copi got %0b exp 0", copi0); end
    checks++; if (if0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", if0.req_ready); end
    checks++; if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b%0b exp 00", if0.busy, if0.done); end
    checks++; if (if0.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp got %h exp 00", if0.rsp_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if0.req_ready !== 1'b1 || if1.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %0b%0b exp 11", if0.req_ready, if1.req_ready); end
  endtask

  task automatic test_write();
    int nl, dn, da, rn, ok;
    run_frame(ADDR_PWM_DUTY, 8'h80, 1'b1, nl, dn, da, rn, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL write_accept got %0d exp 1", ok); end
    checks++; if (cap0 !== 16'h8480) begin errors++; $display("FAIL write_frame got %h exp 8480", cap0); end
    checks++; if (nl !== 132) begin errors++; $display("FAIL write_ncs_low got %0d exp 132", nl); end
    checks++; if (rn !== 16) begin errors++; $display("FAIL write_rises got %0d exp 16", rn); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL write_done_count got %0d exp 1", dn); end
    checks++; if (da !== 132) begin errors++; $display("FAIL write_done_at got %0d exp 132", da); end
    checks++; if (if0.rsp_data !== 8'h00) begin errors++; $display("FAIL write_rsp got %h exp 00", if0.rsp_data); end
  endtask

  task automatic test_back_to_back();
    int acc1 = 0, acc2 = 0, high = 0, ok1 = 0, ok2 = 0, seen_low = 0;
    logic [15:0] f1 = '0, f2;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_addr = ADDR_EN_OUT_7_0; if0.req_data = 8'hFF; if0.req_rw = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (if0.req_ready) begin ok1 = 1; break; end
      @(negedge clk);
    end
    acc1 = cyc + 1;
    @(negedge clk);
    if0.req_addr = ADDR_EN_PWM_7_0; if0.req_data = 8'h0F;
    for (int k = 0; k < 400; k++) begin
      if (!ncs0) seen_low = 1;
      else if (seen_low != 0) high++;
      if (if0.done) f1 = cap0;
      if (if0.req_ready) begin ok2 = 1; acc2 = cyc + 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if0.req_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (if0.req_ready) break;
      @(negedge clk);
    end
    f2 = cap0;
    checks++; if (ok1 !== 1 || ok2 !== 1) begin errors++; $display("FAIL b2b_accept got %0d%0d exp 11", ok1, ok2); end
    checks++; if (acc2 - acc1 !== 137) begin errors++; $display("FAIL b2b_spacing got %0d exp 137", acc2 - acc1); end
    checks++; if (f1 !== 16'h80FF) begin errors++; $display("FAIL b2b_frame1 got %h exp 80ff", f1); end
    checks++; if (f2 !== 16'h820F) begin errors++; $display("FAIL b2b_frame2 got %h exp 820f", f2); end
    checks++; if (high < 4) begin errors++; $display("FAIL b2b_ncs_gap got %0d exp >=4", high); end
  endtask

  task automatic test_clk_div1();
    int ok = 0, nl = 0, tog = 0, r0;
    logic prev;
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_addr = 7'h7F; if1.req_data = 8'hA5; if1.req_rw = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (if1.req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    r0 = rises1;
    @(negedge clk);
    if1.req_valid = 1'b0;
    prev = sclk1;
    for (int k = 0; k < 100; k++) begin
      if (!ncs1) begin nl++; if (sclk1 !== prev) tog++; end
      prev = sclk1;
      if (if1.req_ready) break;
      @(negedge clk);
    end
    checks++; if (ok !== 1) begin errors++; $display("FAIL div1_accept got %0d exp 1", ok); end
    checks++; if (cap1 !== 16'hFFA5) begin errors++; $display("FAIL div1_frame got %h exp ffa5", cap1); end
    checks++; if (nl !== 33) begin errors++; $display("FAIL div1_ncs_low got %0d exp 33", nl); end
    checks++; if (tog !== 32) begin errors++; $display("FAIL div1_sclk_toggles got %0d exp 32", tog); end
    checks++; if (rises1 - r0 !== 16) begin errors++; $display("FAIL div1_rises got %0d exp 16", rises1 - r0); end
  endtask

  task automatic test_reset_mid_frame();
    int ok = 0, hit = 0, dseen = 0, lseen = 0, r0;
    int nl, dn, da, rn, ok2;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_addr = ADDR_EN_OUT_15_8; if0.req_data = 8'h5A; if0.req_rw = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (if0.req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    r0 = rises0;
    @(negedge clk);
    if0.req_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rises0 - r0 == 8) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++; if (ok !== 1 || hit !== 1) begin errors++; $display("FAIL abort_reach_rise8 got %0d%0d exp 11", ok, hit); end
    checks++; if (copi0 !== 1'b1) begin errors++; $display("FAIL abort_copi_bit8 got %0b exp 1", copi0); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ncs0 !== 1'b1 || sclk0 !== 1'b0 || copi0 !== 1'b0) begin errors++; $display("FAIL abort_pins got ncs=%0b sclk=%0b copi=%0b exp 1 0 0", ncs0, sclk0, copi0); end
    checks++; if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin errors++; $display("FAIL abort_busy_done got %0b%0b exp 00", if0.busy, if0.done); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if0.done) dseen++;
      if (!ncs0) lseen++;
    end
    checks++; if (dseen !== 0 || lseen !== 0) begin errors++; $display("FAIL abort_quiet got done=%0d ncs_low=%0d exp 0 0", dseen, lseen); end
    run_frame(ADDR_EN_PWM_15_8, 8'hC3, 1'b1, nl, dn, da, rn, ok2);
    checks++; if (cap0 !== 16'h83C3 || dn !== 1 || nl !== 132) begin errors++; $display("FAIL abort_next_frame got %h done=%0d low=%0d exp 83c3 1 132", cap0, dn, nl); end
  endtask

  task automatic test_busy_pulse();
    int ok = 0, r0, rdy = 0, late_low = 0;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_addr = ADDR_EN_PWM_7_0; if0.req_data = 8'h33; if0.req_rw = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (if0.req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    r0 = rises0;
    @(negedge clk);
    if0.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    if0.req_valid = 1'b1; if0.req_addr = ADDR_PWM_DUTY; if0.req_data = 8'hFF;
    rdy = int'(if0.req_ready);
    @(negedge clk);
    if0.req_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (if0.req_ready) break;
      @(negedge clk);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!ncs0) late_low++;
    end
    checks++; if (ok !== 1 || rdy !== 0) begin errors++; $display("FAIL busy_ready got acc=%0d rdy=%0d exp 1 0", ok, rdy); end
    checks++; if (cap0 !== 16'h8233) begin errors++; $display("FAIL busy_frame got %h exp 8233", cap0); end
    checks++; if (rises0 - r0 !== 16 || late_low !== 0) begin errors++; $display("FAIL busy_single_frame got rises=%0d late_low=%0d exp 16 0", rises0 - r0, late_low); end
  endtask

  task automatic test_rw_field();
    int nl, dn, da, rn, ok;
`ifdef SPI_READ_EN
    run_frame(ADDR_PWM_DUTY, 8'h00, 1'b0, nl, dn, da, rn, ok);
    checks++; if (cap0 !== 16'h0400) begin errors++; $display("FAIL read_frame got %h exp 0400", cap0); end
    checks++; if (if0.rsp_data !== 8'h3C || dn !== 1) begin errors++; $display("FAIL read_rsp got %h done=%0d exp 3c 1", if0.rsp_data, dn); end
    run_frame(ADDR_EN_OUT_7_0, 8'h01, 1'b1, nl, dn, da, rn, ok);
    checks++; if (if0.rsp_data !== 8'h3C) begin errors++; $display("FAIL write_keeps_rsp got %h exp 3c", if0.rsp_data); end
`else
    run_frame(ADDR_PWM_DUTY, 8'h80, 1'b0, nl, dn, da, rn, ok);
    checks++; if (cap0 !== 16'h8480) begin errors++; $display("FAIL rw_forced got %h exp 8480", cap0); end
    checks++; if (if0.rsp_data !== 8'h00 || dn !== 1) begin errors++; $display("FAIL rsp_tied got %h done=%0d exp 00 1", if0.rsp_data, dn); end
`endif
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_data = '0; if0.req_rw = 1'b1;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_data = '0; if1.req_rw = 1'b1;
    test_reset();
    test_write();
    test_back_to_back();
    test_clk_div1();
    test_reset_mid_frame();
    test_busy_pulse();
    test_rw_field();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
